// File: rtl/mips_imem_loader.sv
// Boot-time instruction loader: packs a byte stream big-endian into 32-bit
// words, writes them to instruction memory from address 0 upward, and holds
// the core in reset until the requested number of words has been written.
module mips_imem_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic              clock,
  input  logic              PCreset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_d;
  logic              we_d, busy_d, done_d, err_d, hold_d;
  logic              len_ok_c, accept_c;

  // Legal lengths are 1..DEPTH_WORDS; a byte moves only on a completed handshake.
  assign len_ok_c = (len_words != '0) && (len_words <= LEN_W'(DEPTH_WORDS));
  assign in_ready = (state_q == RECV);
  assign accept_c = in_valid && in_ready;
  assign im_waddr = ptr_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wdata_d = im_wdata;
    we_d    = 1'b0;
    busy_d  = busy;
    done_d  = done;
    err_d   = 1'b0;
    hold_d  = cpu_hold;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok_c) begin
            state_d = RECV;
            last_d  = ADDR_W'(len_words - LEN_W'(1));
            ptr_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept_c) begin
          wdata_d = {im_wdata[23:0], in_byte};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        if (ptr_q == last_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!PCreset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      im_wdata <= '0;
      im_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      im_wdata <= wdata_d;
      im_we    <= we_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cpu_hold <= hold_d;
    end
  end

endmodule
